tick_scheduler: RTL and testbench

//  Multi-channel programmable tick divider with a shared, round-robin arbitrated event output.

---
 rtl/tick_sched_pkg.sv | 14 +
 rtl/tick_sched_rr_pick.sv | 40 ++++
 rtl/tick_scheduler.sv | 120 ++++++++++++
 tb/tb_tick_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared constants and helpers for the tick scheduler.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package tick_sched_pkg;

    localparam int NUM_CH_DEFAULT    = 4;
    localparam int DIV_WIDTH_DEFAULT = 8;

    // Index width for n channels, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_sched_rr_pick.sv
// Round-robin picker: first set request at i_ptr, i_ptr+1, ... (mod NUM_CH).
// Latency: combinational.
// Backpressure: none; the caller decides whether to act on o_any/o_sel.
//   i_req  : request vector          i_ptr : search start index
//   o_any  : at least one request    o_sel : chosen index
module tick_sched_rr_pick
    import tick_sched_pkg::*;
#(
    parameter int  NUM_CH = NUM_CH_DEFAULT,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic              o_any,
    output logic [CH_W-1:0]   o_sel
);

    logic [2*NUM_CH-1:0] w_rot;
    logic [CH_W:0]       w_sum;

    // Rotate the request vector so bit 0 is the channel at i_ptr; scanning
    // downwards lets the smallest offset from the pointer win.
    always_comb begin
        o_any = 1'b0;
        o_sel = '0;
        w_sum = '0;
        w_rot = {i_req, i_req} >> i_ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_any = 1'b1;
                w_sum = {1'b0, i_ptr} + (CH_W+1)'(k);
                if (w_sum >= (CH_W+1)'(NUM_CH)) begin
                    w_sum = w_sum - (CH_W+1)'(NUM_CH);
                end
                o_sel = w_sum[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel programmable tick divider; expiries are serialised round-robin onto one event port.
// Latency: expiry at edge N sets pending, event appears at edge N+1 when the slot is free.
// Backpressure: slot holds while evt_valid & !evt_ready; repeat expiries of a still-pending channel set overrun.
//   tick_in           : count strobe            cfg_we/cfg_ch/cfg_div : per-channel divide write (0 = off)
//   evt_valid/evt_ch  : registered event slot   evt_ready             : consumer accept
//   overrun           : sticky per-channel flag overrun_clr           : write-1-to-clear mask
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int  NUM_CH    = NUM_CH_DEFAULT,
    parameter int  DIV_WIDTH = DIV_WIDTH_DEFAULT,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_in,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 evt_valid,
    output logic [CH_W-1:0]      evt_ch,
    input  logic                 evt_ready,
    output logic [NUM_CH-1:0]    overrun,
    input  logic [NUM_CH-1:0]    overrun_clr
);

    logic [DIV_WIDTH-1:0] r_div [NUM_CH];
    logic [DIV_WIDTH-1:0] r_cnt [NUM_CH];
    logic [NUM_CH-1:0]    r_pend;
    logic [NUM_CH-1:0]    r_ovr;
    logic                 r_vld;
    logic [CH_W-1:0]      r_ch;
    logic [CH_W-1:0]      r_rr;

    logic                 w_free;
    logic                 w_any;
    logic [CH_W-1:0]      w_sel;
    logic                 w_take;
    logic [NUM_CH-1:0]    w_wr;
    logic [NUM_CH-1:0]    w_exp;
    logic [NUM_CH-1:0]    w_gnt;

    assign w_free = !r_vld || evt_ready;
    assign w_take = w_free && w_any;

    tick_sched_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .i_req (r_pend),
        .i_ptr (r_rr),
        .o_any (w_any),
        .o_sel (w_sel)
    );

    // Equality against the loop index also rejects cfg_ch >= NUM_CH.
    // A config write suppresses that channel's expiry for the cycle.
    always_comb begin
        w_wr  = '0;
        w_exp = '0;
        w_gnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i]  = cfg_we && (int'(cfg_ch) == i);
            w_exp[i] = tick_in && (r_div[i] != '0) && !w_wr[i]
                       && (r_cnt[i] == r_div[i] - DIV_WIDTH'(1));
            w_gnt[i] = w_take && (int'(w_sel) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_pend <= '0;
            r_ovr  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr[i]) begin
                    r_div[i]  <= cfg_div;
                    r_cnt[i]  <= '0;
                    r_pend[i] <= 1'b0;
                end else begin
                    if (tick_in && (r_div[i] != '0)) begin
                        r_cnt[i] <= w_exp[i] ? '0 : r_cnt[i] + DIV_WIDTH'(1);
                    end
                    // A fresh expiry keeps the bit set even when the old
                    // request is granted in the same cycle.
                    if (w_exp[i]) begin
                        r_pend[i] <= 1'b1;
                    end else if (w_gnt[i]) begin
                        r_pend[i] <= 1'b0;
                    end
                end
                // Set beats clear.
                r_ovr[i] <= (w_exp[i] && r_pend[i] && !w_gnt[i])
                            || (r_ovr[i] && !overrun_clr[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_ch  <= '0;
            r_rr  <= '0;
        end else if (w_take) begin
            r_vld <= 1'b1;
            r_ch  <= w_sel;
            r_rr  <= (int'(w_sel) == NUM_CH - 1) ? '0 : w_sel + CH_W'(1);
        end else if (w_free) begin
            r_vld <= 1'b0;
        end
    end

    assign evt_valid = r_vld;
    assign evt_ch    = r_ch;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

    localparam int NCH = 4;

    logic       clk;
    logic       rst_n;
    logic       tick_in;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_ready;
    logic [3:0] overrun;
    logic [3:0] overrun_clr;

    int n_checks = 0;
    int n_errors = 0;
    bit run_chk  = 0;

    tick_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .evt_valid   (evt_valid),
        .evt_ch      (evt_ch),
        .evt_ready   (evt_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int unsigned m_div  [NCH] = '{default: 0};
    int unsigned m_cnt  [NCH] = '{default: 0};
    bit          m_pend [NCH] = '{default: 0};
    bit          m_ov   [NCH] = '{default: 0};
    bit          m_vld = 0;
    int          m_ch  = 0;
    int          m_rr  = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int unsigned nd [NCH];
        int unsigned nc [NCH];
        bit          np [NCH];
        bit          no [NCH];
        bit          free;
        int          g;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_div[i]  <= 0;
                m_cnt[i]  <= 0;
                m_pend[i] <= 0;
                m_ov[i]   <= 0;
            end
            m_vld <= 0;
            m_ch  <= 0;
            m_rr  <= 0;
        end else begin
            nd = m_div; nc = m_cnt; np = m_pend; no = m_ov;
            free = !m_vld || evt_ready;
            g = -1;
            if (free) begin
                for (int k = 0; k < NCH; k++) begin
                    if (g < 0 && m_pend[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                no[i] = m_ov[i] && !overrun_clr[i];
                if (g == i) np[i] = 0;
                if (cfg_we && int'(cfg_ch) == i) begin
                    nd[i] = cfg_div;
                    nc[i] = 0;
                    np[i] = 0;
                end else if (tick_in && m_div[i] != 0) begin
                    if (m_cnt[i] + 1 == m_div[i]) begin
                        if (m_pend[i] && g != i) no[i] = 1;
                        np[i] = 1;
                        nc[i] = 0;
                    end else begin
                        nc[i] = m_cnt[i] + 1;
                    end
                end
            end
            m_div <= nd; m_cnt <= nc; m_pend <= np; m_ov <= no;
            if (g >= 0) begin
                m_vld <= 1;
                m_ch  <= g;
                m_rr  <= (g + 1) % NCH;
            end else if (free) begin
                m_vld <= 0;
            end
        end
    end

    function automatic logic [3:0] ov_vec();
        logic [3:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_ov[i];
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run_chk && rst_n) begin
            chk("model evt_valid", evt_valid, m_vld);
            if (m_vld) chk("model evt_ch", evt_ch, m_ch);
            chk("model overrun", overrun, ov_vec());
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit tk, input bit we, input int ch, input int dv,
                        input bit rdy, input logic [3:0] clr);
        tick_in     = tk;
        cfg_we      = we;
        cfg_ch      = 2'(ch);
        cfg_div     = 8'(dv);
        evt_ready   = rdy;
        overrun_clr = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expv(input string nm, input bit v, input int ch);
        chk({nm, " valid"}, evt_valid, v);
        if (v) chk({nm, " ch"}, evt_ch, ch);
    endtask

    initial begin
        rst_n = 0; tick_in = 0; cfg_we = 0; cfg_ch = 0; cfg_div = 0;
        evt_ready = 1; overrun_clr = 0;
        repeat (3) @(negedge clk);
        chk("reset evt_valid", evt_valid, 1'b0);
        chk("reset evt_ch", evt_ch, 2'd0);
        chk("reset overrun", overrun, 4'd0);
        rst_n   = 1;
        run_chk = 1;

        // All four channels expire on one tick: serviced 0,1,2,3, pointer wraps, twice.
        for (int i = 0; i < NCH; i++) step(0, 1, i, 1, 1, 0);
        for (int r = 0; r < 2; r++) begin
            step(1, 0, 0, 0, 1, 0);
            expv("rr tick", 0, 0);
            for (int i = 0; i < NCH; i++) begin
                step(0, 0, 0, 0, 1, 0);
                expv("rr order", 1, i);
            end
            step(0, 0, 0, 0, 1, 0);
            expv("rr drained", 0, 0);
        end
        for (int i = 0; i < NCH; i++) step(0, 1, i, 0, 1, 0);

        // Divide by 3 over 9 ticks: events one cycle after ticks 3, 6, 9.
        step(0, 1, 0, 3, 1, 0);
        for (int t = 1; t <= 9; t++) begin
            step(1, 0, 0, 0, 1, 0);
            expv("div3", (t == 4 || t == 7), 0);
        end
        step(0, 0, 0, 0, 1, 0);
        expv("div3 last", 1, 0);
        step(0, 0, 0, 0, 1, 0);
        expv("div3 idle", 0, 0);
        step(0, 1, 0, 0, 1, 0);

        // Overrun on a stalled slot; set wins over clear; clear alone.
        step(0, 1, 2, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expv("ovr t1", 0, 0);
        step(1, 0, 0, 0, 0, 0);
        expv("ovr t2", 1, 2);
        chk("ovr t2 flag", overrun, 4'b0000);
        step(1, 0, 0, 0, 0, 0);
        chk("ovr t3 flag", overrun, 4'b0100);
        step(1, 0, 0, 0, 0, 4'b0100);
        chk("ovr set beats clr", overrun, 4'b0100);
        step(0, 0, 0, 0, 0, 4'b0100);
        chk("ovr cleared", overrun, 4'b0000);
        expv("ovr slot held", 1, 2);
        step(0, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        expv("ovr drop pending", 0, 0);

        // Reprogram mid-count together with a tick: count restarts.
        step(0, 1, 1, 4, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 1, 2, 1, 0);
        expv("recfg", 0, 0);
        step(1, 0, 0, 0, 1, 0);
        expv("recfg t1", 0, 0);
        step(1, 0, 0, 0, 1, 0);
        expv("recfg t2", 0, 0);
        step(0, 0, 0, 0, 1, 0);
        expv("recfg evt", 1, 1);
        step(0, 1, 1, 0, 1, 0);
        expv("recfg idle", 0, 0);

        // Disabling a pending channel drops the request but not the slot.
        step(0, 1, 3, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        expv("dis slot", 1, 3);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0);
        expv("dis keep slot", 1, 3);
        chk("dis no overrun", overrun, 4'b0000);
        step(0, 0, 0, 0, 1, 0);
        expv("dis dropped", 0, 0);
        step(0, 0, 0, 0, 1, 0);
        expv("dis dropped2", 0, 0);

        // Asynchronous reset while the slot is full.
        step(0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        expv("pre-reset", 1, 0);
        #2 rst_n = 0;
        #1;
        chk("async rst valid", evt_valid, 1'b0);
        chk("async rst ch", evt_ch, 2'd0);
        @(negedge clk);
        rst_n = 1;
        for (int t = 0; t < 5; t++) begin
            step(1, 0, 0, 0, 1, 0);
            expv("post-reset silent", 0, 0);
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit         tk, we, rdy;
            int         ch, dv;
            logic [3:0] clr;
            tk  = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 7) == 0);
            ch  = $urandom_range(0, NCH - 1);
            dv  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step(tk, we, ch, dv, rdy, clr);
        end

        run_chk = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
